// File: rtl/mips_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mips_fetch_queue
// Purpose  : Instruction prefetch FIFO (FWFT) feeding the IF/ID register,
//            with branch redirect flush and HLT-driven prefetch stop.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mips_fetch_queue #(
  parameter int         DEPTH  = 4,
  parameter int         AW     = 10,
  parameter logic [5:0] HLT_OP = 6'b001000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_npc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                c_PW    = $clog2(DEPTH);
  localparam int                c_CW    = c_PW + 1;
  localparam logic [c_CW:0]     c_DEPTH = (c_CW + 1)'(DEPTH);

  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_req_pc;
  logic              r_inflight;
  logic              r_stopped;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_CW-1:0]   r_count;
  logic [31:0]       r_data [DEPTH];
  logic [31:0]       r_npc  [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_hlt;
  logic [c_CW:0]     w_occ;

  assign w_pop  = (r_count != '0) && !stall;
  // A response arriving after HLT has been queued belongs to a squashed fetch.
  assign w_push = r_inflight && !r_stopped;
  assign w_hlt  = (imem_rdata[31:26] == HLT_OP);
  assign w_occ  = {1'b0, r_count} + (c_CW + 1)'(r_inflight) - (c_CW + 1)'(w_pop);

  assign imem_req   = !rst && !redirect_valid && !r_stopped && (w_occ < c_DEPTH);
  assign imem_addr  = r_fetch_pc[AW-1:0];
  assign inst_valid = (r_count != '0);
  assign inst       = r_data[r_rd_ptr];
  assign inst_npc   = r_npc[r_rd_ptr];
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_stopped  <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_npc[i]  <= '0;
      end
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_stopped  <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd1;
      end
      if (w_push) begin
        r_data[r_wr_ptr] <= imem_rdata;
        r_npc[r_wr_ptr]  <= r_req_pc + 32'd1;
        r_wr_ptr         <= r_wr_ptr + c_PW'(1);
        if (w_hlt) begin
          r_stopped <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mips_fetch_queue
// Purpose  : Directed table-driven bench for mips_fetch_queue.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mips_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_npc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [1024];

  mips_fetch_queue #(.DEPTH(4), .AW(10), .HLT_OP(6'b001000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_npc(inst_npc), .count(count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data returned the cycle after a request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  typedef struct {
    bit rs;     // pulse reset for one cycle before this vector
    bit rst;
    bit stall;
    bit redir;
    int rpc;
    bit req;
    int addr;   // -1: don't care
    bit valid;
    int k;      // expected head = mem[k], npc = k+1; -1: don't care
    int cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rs, bit r, bit s, bit rd, int rpc,
                              bit req, int addr, bit valid, int k, int cnt);
    vec_t v;
    v = '{rs, r, s, rd, rpc, req, addr, valid, k, cnt};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    if (v.rs) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(v.rst, v.stall, v.redir, 32'(v.rpc));
    tag = $sformatf("v%0d", idx);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, v.req});
    if (v.addr >= 0) chk({tag, ".addr"}, {22'd0, imem_addr}, 32'(v.addr));
    chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v.valid});
    chk({tag, ".count"}, {29'd0, count}, 32'(v.cnt));
    if (v.k >= 0) begin
      chk({tag, ".inst"}, inst, mem[v.k]);
      chk({tag, ".npc"}, inst_npc, 32'(v.k + 1));
    end
  endtask

  logic [31:0] got_i[$];
  logic [31:0] got_n[$];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0020 | (32'(i) << 11);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.count", {29'd0, count}, 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.npc", inst_npc, 32'd0);

    // Streaming, redirect with word 7 in flight, then reset mid-operation
    add(0,0,0,0,0,  1,0,0,-1,0);
    add(0,0,0,0,0,  1,1,0,-1,0);
    add(0,0,0,0,0,  1,2,1,0,1);
    add(0,0,0,0,0,  1,3,1,1,1);
    add(0,0,0,0,0,  1,4,1,2,1);
    add(0,0,0,0,0,  1,5,1,3,1);
    add(0,0,0,0,0,  1,6,1,4,1);
    add(0,0,0,0,0,  1,7,1,5,1);
    add(0,0,0,1,20, 0,8,1,6,1);
    add(0,0,0,0,0,  1,20,0,-1,0);
    add(0,0,0,0,0,  1,21,0,-1,0);
    add(0,0,0,0,0,  1,22,1,20,1);
    add(0,0,1,0,0,  1,23,1,21,1);
    add(0,0,1,0,0,  1,24,1,21,2);
    add(0,1,1,0,0,  0,-1,1,21,3);
    add(0,0,0,0,0,  1,0,0,-1,0);
    add(0,0,0,0,0,  1,1,0,-1,0);
    add(0,0,0,0,0,  1,2,1,0,1);
    // Backpressure to full, single-cycle pops at full and with a response pending
    add(1,0,1,0,0,  1,0,0,-1,0);
    add(0,0,1,0,0,  1,1,0,-1,0);
    add(0,0,1,0,0,  1,2,1,0,1);
    add(0,0,1,0,0,  1,3,1,0,2);
    add(0,0,1,0,0,  0,-1,1,0,3);
    add(0,0,1,0,0,  0,-1,1,0,4);
    add(0,0,1,0,0,  0,-1,1,0,4);
    add(0,0,0,0,0,  1,4,1,0,4);
    add(0,0,0,0,0,  1,5,1,1,3);
    add(0,0,1,0,0,  0,-1,1,2,3);
    add(0,0,1,0,0,  0,-1,1,2,4);
    add(0,0,0,0,0,  1,6,1,2,4);
    add(0,0,0,0,0,  1,7,1,3,3);
    add(0,0,0,0,0,  1,8,1,4,3);
    add(0,0,0,0,0,  1,9,1,5,3);
    add(0,0,0,0,0,  1,10,1,6,3);

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Address wrap: imem_addr wraps at 2^AW while inst_npc keeps counting
    cyc(1'b0, 1'b0, 1'b1, 32'd1023);
    chk("wrap.req0", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap.addr1023", {22'd0, imem_addr}, 32'd1023);
    chk("wrap.valid0", {31'd0, inst_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap.addr0", {22'd0, imem_addr}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap.inst1023", inst, mem[1023]);
    chk("wrap.npc1024", inst_npc, 32'd1024);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap.inst0", inst, mem[0]);
    chk("wrap.npc1025", inst_npc, 32'd1025);

    // HLT at word 3: deliver 0..3, then idle until redirect
    mem[3] = 32'h2000_0000;
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 12; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      if (inst_valid) begin
        got_i.push_back(inst);
        got_n.push_back(inst_npc);
      end
    end
    chk("hlt.ndelivered", 32'(got_i.size()), 32'd4);
    for (int i = 0; i < got_i.size() && i < 4; i++) begin
      chk($sformatf("hlt.inst%0d", i), got_i[i], mem[i]);
      chk($sformatf("hlt.npc%0d", i), got_n[i], 32'(i + 1));
    end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      chk("hlt.idle_req", {31'd0, imem_req}, 32'd0);
      chk("hlt.idle_valid", {31'd0, inst_valid}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b1, 32'd0);
    chk("hlt.redir_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("hlt.restart_req", {31'd0, imem_req}, 32'd1);
    chk("hlt.restart_addr", {22'd0, imem_addr}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("hlt.restart_inst", inst, mem[0]);
    chk("hlt.restart_npc", inst_npc, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
